// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: accumulator FSM states, add/sub opcodes and
// saturation bounds for a two's-complement word of any width.
package fxp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } fxp_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Results are 64 bits wide; callers truncate to their own width.
    function automatic logic [63:0] FXP_MAX(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] FXP_MIN(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_point_accumulator_if.sv
// Term-in / result-out bundle of the fixed-point accumulator. The slave
// modport is the accumulator side; master is whoever feeds and drains it.
interface fixed_point_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] init_value;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_op;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_overflow;
    logic             out_trunc;
    logic [CNT_W-1:0] term_count;

    modport slave (
        input  start, init_value, in_valid, in_data, in_op, in_last, out_ready,
        output in_ready, out_valid, out_data, out_overflow, out_trunc, term_count
    );

    modport master (
        output start, init_value, in_valid, in_data, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, out_trunc, term_count
    );
endinterface

// File: rtl/FixedPoint_AdderSub_Baseline.sv
// Combinational two's-complement adder/subtractor; subtract is invert+1 via
// carry-in, and overflowFlag reports a signed result outside the word range.
module FixedPoint_AdderSub_Baseline
    import fxp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] sum,
    output logic             overflowFlag
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] cin;

    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign cin   = {{(WIDTH-1){1'b0}}, (op == OP_SUB)};
    assign sum   = a + b_eff + cin;

    // Subtracting the most-negative value yields b_eff = MAX with carry-in,
    // so the same sign rule flags it correctly.
    assign overflowFlag = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/fixed_point_accumulator.sv
// Saturating running-sum stage: seeds from init_value, folds in one streamed
// term per cycle through the adder/subtractor, then presents the result.
//
//  state    | meaning
//  ST_IDLE  | waiting for start; last result still visible on the outputs
//  ST_ACCUM | accepting terms, one per cycle, until in_last or MAX_TERMS
//  ST_DONE  | result valid, held until out_ready
module fixed_point_accumulator
    import fxp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_TERMS = 255,
    parameter int CNT_W     = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    fixed_point_accumulator_if.slave bus
);
    localparam logic [WIDTH-1:0] SAT_MAX  = WIDTH'(FXP_MAX(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN  = WIDTH'(FXP_MIN(WIDTH));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

    fxp_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             trunc_q, trunc_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;

    FixedPoint_AdderSub_Baseline #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a           (acc_q),
        .b           (bus.in_data),
        .op          (bus.in_op),
        .sum         (add_sum),
        .overflowFlag(add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        trunc_d = trunc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.init_value;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    // Overflow only happens when both operands share a's sign,
                    // so clamping toward a's sign picks the correct rail.
                    if (add_ovf) begin
                        acc_d = acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = add_sum;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (bus.in_last) begin
                        state_d = ST_DONE;
                    end else if (cnt_q == LAST_CNT) begin
                        trunc_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_ACCUM);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.out_data     = acc_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_trunc    = trunc_q;
    assign bus.term_count   = cnt_q;
endmodule
